// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC register block and the BIOS/OS watchdog:
// watchdog state encoding, WatchDogReg field positions and register addresses.
package lpc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        WARN   = 2'd2,
        EXPIRE = 2'd3
    } wdt_state_t;

    localparam int unsigned WDT_EN_BIT     = 7;
    localparam int unsigned WDT_IRQ_EN_BIT = 6;
    localparam int unsigned WDT_TO_MSB     = 5;

    localparam logic [7:0] LPC_ADDR_WDT_LOAD  = 8'h0B;
    localparam logic [7:0] LPC_ADDR_WDT_CLEAR = 8'h0C;

    // A zero timeout field stands for the maximum of 64 ticks.
    function automatic logic [6:0] decode_timeout(input logic [WDT_TO_MSB:0] field);
        return (field == '0) ? 7'd64 : {1'b0, field};
    endfunction

endpackage

// File: rtl/wdt_prescaler.sv
// Watchdog tick generator: free-running modulo-TICK_CYCLES counter with a
// synchronous clear, flagging the last count of each period as a tick.
module wdt_prescaler #(
    parameter int unsigned TICK_CYCLES = 33_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/bios_wdt_timer.sv
// BIOS/OS watchdog: down-counts coarse ticks after a software kick, raises a
// pre-expiry IREQ, then latches WatchDogOccurred and stretches a reset request.
module bios_wdt_timer
    import lpc_pkg::*;
#(
    parameter int unsigned TICK_CYCLES  = 33_000_000,
    parameter int unsigned WARN_TICKS   = 2,
    parameter int unsigned RESET_CYCLES = 16
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic [7:0] WatchDogReg,
    input  logic       LoadWDTimer,
    input  logic       ClearStatus,
    output logic       WatchDogIREQ,
    output logic       WatchDogOccurred,
    output logic       WdtResetReq,
    output logic [6:0] WdtCount
);

    localparam int unsigned PW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(RESET_CYCLES - 1);

    wdt_state_t    state_q, state_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [PW-1:0] pulse_q, pulse_d;
    logic          rreq_q, rreq_d;
    logic          occ_q, occ_d;
    logic          pre_clr;
    logic          tick;
    logic          wdt_en;
    logic [6:0]    timeout;
    logic [6:0]    cnt_dec;

    assign wdt_en  = WatchDogReg[WDT_EN_BIT];
    assign timeout = decode_timeout(WatchDogReg[WDT_TO_MSB:0]);
    assign cnt_dec = cnt_q - 7'd1;

    wdt_prescaler #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_prescaler (
        .clk_i (LpcClock),
        .rst_i (PciReset),
        .clr_i (pre_clr),
        .tick_o(tick)
    );

    // Priority in RUN/WARN: disable, then kick, then tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        rreq_d  = rreq_q;
        occ_d   = ClearStatus ? 1'b0 : occ_q;
        pre_clr = 1'b1;
        case (state_q)
            IDLE: begin
                rreq_d = 1'b0;
                if (LoadWDTimer && wdt_en) begin
                    state_d = RUN;
                    cnt_d   = timeout;
                end
            end
            RUN, WARN: begin
                pre_clr = 1'b0;
                if (!wdt_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pre_clr = 1'b1;
                end else if (LoadWDTimer) begin
                    state_d = RUN;
                    cnt_d   = timeout;
                    pre_clr = 1'b1;
                end else if (tick) begin
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) begin
                        state_d = EXPIRE;
                        occ_d   = 1'b1;
                        rreq_d  = 1'b1;
                        pulse_d = PULSE_LAST;
                    end else if (cnt_dec <= 7'(WARN_TICKS)) begin
                        state_d = WARN;
                    end
                end
            end
            EXPIRE: begin
                if (pulse_q == '0) begin
                    state_d = IDLE;
                    rreq_d  = 1'b0;
                end else begin
                    pulse_d = pulse_q - PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                rreq_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge LpcClock) begin
        if (PciReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= '0;
            rreq_q  <= 1'b0;
            occ_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            rreq_q  <= rreq_d;
            occ_q   <= occ_d;
        end
    end

    assign WatchDogIREQ     = (state_q == WARN) && WatchDogReg[WDT_IRQ_EN_BIT];
    assign WatchDogOccurred = occ_q;
    assign WdtResetReq      = rreq_q;
    assign WdtCount         = cnt_q;

endmodule

// File: tb/tb_bios_wdt_timer.sv
// Directed bench for bios_wdt_timer with TICK_CYCLES=4, WARN_TICKS=2,
// RESET_CYCLES=3; expected values are hand-derived per scenario.
module tb_bios_wdt_timer;
    import lpc_pkg::*;

    logic       LpcClock = 1'b0;
    logic       PciReset;
    logic [7:0] WatchDogReg;
    logic       LoadWDTimer;
    logic       ClearStatus;
    logic       WatchDogIREQ;
    logic       WatchDogOccurred;
    logic       WdtResetReq;
    logic [6:0] WdtCount;

    int errors = 0;
    int checks = 0;

    bios_wdt_timer #(
        .TICK_CYCLES (4),
        .WARN_TICKS  (2),
        .RESET_CYCLES(3)
    ) dut (
        .LpcClock        (LpcClock),
        .PciReset        (PciReset),
        .WatchDogReg     (WatchDogReg),
        .LoadWDTimer     (LoadWDTimer),
        .ClearStatus     (ClearStatus),
        .WatchDogIREQ    (WatchDogIREQ),
        .WatchDogOccurred(WatchDogOccurred),
        .WdtResetReq     (WdtResetReq),
        .WdtCount        (WdtCount)
    );

    always #5 LpcClock = ~LpcClock;

    task automatic step();
        @(posedge LpcClock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic kick(input logic [7:0] reg_val);
        WatchDogReg = reg_val;
        LoadWDTimer = 1'b1;
        step();
        LoadWDTimer = 1'b0;
    endtask

    task automatic test_reset();
        PciReset    = 1'b1;
        LoadWDTimer = 1'b0;
        ClearStatus = 1'b0;
        WatchDogReg = 8'h00;
        step();
        checks++;
        if ({WatchDogIREQ, WatchDogOccurred, WdtResetReq, WdtCount} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got irq=%b occ=%b rr=%b cnt=%0d, want all 0",
                     WatchDogIREQ, WatchDogOccurred, WdtResetReq, WdtCount);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
        end
        PciReset = 1'b0;
    endtask

    task automatic test_basic_expiry();
        int exp_cnt;
        logic exp_irq, exp_rr, exp_occ;
        test_reset();
        kick(8'hC5);
        for (int k = 0; k <= 23; k++) begin
            if (k > 0) step();
            exp_cnt = (k < 20) ? 5 - k / 4 : 0;
            exp_irq = (k >= 12) && (k < 20);
            exp_rr  = (k >= 20) && (k <= 22);
            exp_occ = (k >= 20);
            checks++;
            if (WdtCount !== 7'(exp_cnt) || WatchDogIREQ !== exp_irq ||
                WdtResetReq !== exp_rr || WatchDogOccurred !== exp_occ) begin
                errors++;
                $display("FAIL basic_expiry k=%0d: got cnt=%0d irq=%b rr=%b occ=%b, want cnt=%0d irq=%b rr=%b occ=%b",
                         k, WdtCount, WatchDogIREQ, WdtResetReq, WatchDogOccurred,
                         exp_cnt, exp_irq, exp_rr, exp_occ);
            end
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL basic_idle_after_pulse: got %0d want IDLE", dut.state_q);
        end
    endtask

    task automatic test_periodic_kick();
        int exp_cnt;
        test_reset();
        kick(8'hC5);
        for (int i = 1; i <= 200; i++) begin
            LoadWDTimer = (i % 12 == 0);
            step();
            LoadWDTimer = 1'b0;
            exp_cnt = 5 - (i % 12) / 4;
            checks++;
            if (WdtCount !== 7'(exp_cnt) || WatchDogIREQ !== 1'b0 ||
                WdtResetReq !== 1'b0 || WatchDogOccurred !== 1'b0) begin
                errors++;
                $display("FAIL periodic_kick i=%0d: got cnt=%0d irq=%b rr=%b occ=%b, want cnt=%0d irq=0 rr=0 occ=0",
                         i, WdtCount, WatchDogIREQ, WdtResetReq, WatchDogOccurred, exp_cnt);
            end
        end
    endtask

    task automatic test_kick_tick_collision();
        test_reset();
        kick(8'hC5);
        steps(15);
        checks++;
        if (dut.state_q !== WARN || WdtCount !== 7'd2 || WatchDogIREQ !== 1'b1) begin
            errors++;
            $display("FAIL collision_pre: got state=%0d cnt=%0d irq=%b, want WARN cnt=2 irq=1",
                     dut.state_q, WdtCount, WatchDogIREQ);
        end
        kick(8'hC5);
        checks++;
        if (dut.state_q !== RUN || WdtCount !== 7'd5 || WatchDogIREQ !== 1'b0) begin
            errors++;
            $display("FAIL collision_reload: got state=%0d cnt=%0d irq=%b, want RUN cnt=5 irq=0",
                     dut.state_q, WdtCount, WatchDogIREQ);
        end
        steps(3);
        checks++;
        if (WdtCount !== 7'd5) begin
            errors++;
            $display("FAIL collision_prescaler_clear: got cnt=%0d want 5", WdtCount);
        end
        step();
        checks++;
        if (WdtCount !== 7'd4) begin
            errors++;
            $display("FAIL collision_first_tick: got cnt=%0d want 4", WdtCount);
        end
    endtask

    task automatic test_field_change();
        test_reset();
        kick(8'hC5);
        WatchDogReg = 8'hC1;
        steps(4);
        checks++;
        if (WdtCount !== 7'd4 || dut.state_q !== RUN) begin
            errors++;
            $display("FAIL field_change_midcount: got cnt=%0d state=%0d, want cnt=4 RUN",
                     WdtCount, dut.state_q);
        end
        kick(8'hC1);
        checks++;
        if (WdtCount !== 7'd1) begin
            errors++;
            $display("FAIL field_change_reload: got cnt=%0d want 1", WdtCount);
        end
    endtask

    task automatic test_disable_and_mask();
        test_reset();
        kick(8'hC5);
        steps(12);
        checks++;
        if (WatchDogIREQ !== 1'b1) begin
            errors++;
            $display("FAIL disable_pre_irq: got %b want 1", WatchDogIREQ);
        end
        WatchDogReg = 8'h45;
        step();
        checks++;
        if (dut.state_q !== IDLE || WdtCount !== 7'd0 || WatchDogIREQ !== 1'b0) begin
            errors++;
            $display("FAIL disable_in_warn: got state=%0d cnt=%0d irq=%b, want IDLE cnt=0 irq=0",
                     dut.state_q, WdtCount, WatchDogIREQ);
        end
        kick(8'hC5);
        steps(4);
        checks++;
        if (WdtCount !== 7'd4) begin
            errors++;
            $display("FAIL disable_reenable: got cnt=%0d want 4", WdtCount);
        end

        test_reset();
        kick(8'h85);
        steps(12);
        checks++;
        if (dut.state_q !== WARN || WdtCount !== 7'd2 || WatchDogIREQ !== 1'b0) begin
            errors++;
            $display("FAIL mask_warn: got state=%0d cnt=%0d irq=%b, want WARN cnt=2 irq=0",
                     dut.state_q, WdtCount, WatchDogIREQ);
        end
        WatchDogReg = 8'hC5;
        #1;
        checks++;
        if (WatchDogIREQ !== 1'b1) begin
            errors++;
            $display("FAIL mask_live_unmask: got irq=%b want 1", WatchDogIREQ);
        end
        WatchDogReg = 8'h85;

        test_reset();
        kick(8'h45);
        checks++;
        if (dut.state_q !== IDLE || WdtCount !== 7'd0) begin
            errors++;
            $display("FAIL idle_kick_disabled: got state=%0d cnt=%0d, want IDLE cnt=0",
                     dut.state_q, WdtCount);
        end
    endtask

    task automatic test_field0_clear_race();
        test_reset();
        kick(8'h80);
        checks++;
        if (WdtCount !== 7'd64) begin
            errors++;
            $display("FAIL field0_load: got cnt=%0d want 64", WdtCount);
        end
        steps(4);
        checks++;
        if (WdtCount !== 7'd63) begin
            errors++;
            $display("FAIL field0_first_tick: got cnt=%0d want 63", WdtCount);
        end
        steps(251);
        checks++;
        if (WdtCount !== 7'd1 || dut.state_q !== WARN || WatchDogOccurred !== 1'b0 ||
            WatchDogIREQ !== 1'b0) begin
            errors++;
            $display("FAIL field0_pre_expiry: got cnt=%0d state=%0d occ=%b irq=%b, want cnt=1 WARN occ=0 irq=0",
                     WdtCount, dut.state_q, WatchDogOccurred, WatchDogIREQ);
        end
        ClearStatus = 1'b1;
        step();
        ClearStatus = 1'b0;
        checks++;
        if (WatchDogOccurred !== 1'b1 || WdtResetReq !== 1'b1 || dut.state_q !== EXPIRE) begin
            errors++;
            $display("FAIL clear_race_set_wins: got occ=%b rr=%b state=%0d, want occ=1 rr=1 EXPIRE",
                     WatchDogOccurred, WdtResetReq, dut.state_q);
        end
        step();
        ClearStatus = 1'b1;
        step();
        ClearStatus = 1'b0;
        checks++;
        if (WatchDogOccurred !== 1'b0) begin
            errors++;
            $display("FAIL clear_later: got occ=%b want 0", WatchDogOccurred);
        end
    endtask

    task automatic test_short_timeouts();
        test_reset();
        kick(8'hC2);
        steps(4);
        checks++;
        if (dut.state_q !== WARN || WdtCount !== 7'd1 || WatchDogIREQ !== 1'b1) begin
            errors++;
            $display("FAIL timeout2_warn: got state=%0d cnt=%0d irq=%b, want WARN cnt=1 irq=1",
                     dut.state_q, WdtCount, WatchDogIREQ);
        end
    endtask

    task automatic test_reset_mid_pulse();
        test_reset();
        kick(8'hC1);
        steps(3);
        checks++;
        if (dut.state_q !== RUN || WdtCount !== 7'd1 || WatchDogIREQ !== 1'b0) begin
            errors++;
            $display("FAIL timeout1_no_warn: got state=%0d cnt=%0d irq=%b, want RUN cnt=1 irq=0",
                     dut.state_q, WdtCount, WatchDogIREQ);
        end
        step();
        checks++;
        if (dut.state_q !== EXPIRE || WdtResetReq !== 1'b1 || WatchDogOccurred !== 1'b1) begin
            errors++;
            $display("FAIL timeout1_expire: got state=%0d rr=%b occ=%b, want EXPIRE rr=1 occ=1",
                     dut.state_q, WdtResetReq, WatchDogOccurred);
        end
        PciReset = 1'b1;
        step();
        checks++;
        if ({WatchDogIREQ, WatchDogOccurred, WdtResetReq, WdtCount} !== 10'd0 ||
            dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_mid_pulse: got irq=%b occ=%b rr=%b cnt=%0d state=%0d, want all 0 IDLE",
                     WatchDogIREQ, WatchDogOccurred, WdtResetReq, WdtCount, dut.state_q);
        end
        PciReset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (WdtResetReq !== 1'b0 || dut.state_q !== IDLE) begin
                errors++;
                $display("FAIL post_reset_residual i=%0d: got rr=%b state=%0d, want rr=0 IDLE",
                         i, WdtResetReq, dut.state_q);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        PciReset    = 1'b1;
        LoadWDTimer = 1'b0;
        ClearStatus = 1'b0;
        WatchDogReg = 8'h00;
        test_reset();
        test_basic_expiry();
        test_periodic_kick();
        test_kick_tick_collision();
        test_field_change();
        test_disable_and_mask();
        test_field0_clear_race();
        test_short_timeouts();
        test_reset_mid_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
